// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory shared by instruction fetch and data access.
// Define ARB_RR_EN for round-robin arbitration on contention; default is fixed data priority.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic [63:0] d_rdata,
    output logic        d_ack,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic        mem_ready,
    output logic        stall
);
    typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;
    state_t      state_q, state_d;
    logic [63:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, d_rdata_q, d_rdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic        if_ack_q, if_ack_d, d_ack_q, d_ack_d;
    logic        if_go, d_go, pick_d, grant, done;
`ifdef ARB_RR_EN
    logic        last_data_q, last_data_d;
`endif
    always_comb begin
        // a requester still holds req during its ack cycle; that request is already served
        if_go = if_req & ~if_ack_q;
        d_go = d_req & ~d_ack_q;
        grant = (state_q == IDLE) & (if_go | d_go);
        done = (state_q != IDLE) & mem_ready;
`ifdef ARB_RR_EN
        pick_d = d_go & (~if_go | ~last_data_q);
        last_data_d = grant ? pick_d : last_data_q;
`else
        pick_d = d_go;
`endif
        state_d = (state_q == IDLE) ? (pick_d ? D_BUSY : (if_go ? IF_BUSY : IDLE)) :
                  (done ? IDLE : state_q);
        mem_addr_d = grant ? (pick_d ? d_addr : if_addr) : mem_addr_q;
        mem_wdata_d = (grant & pick_d) ? d_wdata : mem_wdata_q;
        mem_read_d = grant ? (~pick_d | ~d_we) : (done ? 1'b0 : mem_read_q);
        mem_write_d = grant ? (pick_d & d_we) : (done ? 1'b0 : mem_write_q);
        if_ack_d = done & (state_q == IF_BUSY);
        d_ack_d = done & (state_q == D_BUSY);
        // fetch address is held in mem_addr for the whole access, so bit 2 picks the word
        if_rdata_d = if_ack_d ? (mem_addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0]) : if_rdata_q;
        d_rdata_d = (d_ack_d & mem_read_q) ? mem_rdata : d_rdata_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mem_addr_q <= '0;
            mem_wdata_q <= '0;
            mem_read_q <= 1'b0;
            mem_write_q <= 1'b0;
            if_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef ARB_RR_EN
            last_data_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q <= mem_read_d;
            mem_write_q <= mem_write_d;
            if_ack_q <= if_ack_d;
            d_ack_q <= d_ack_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef ARB_RR_EN
            last_data_q <= last_data_d;
`endif
        end
    end
    assign mem_addr = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read = mem_read_q;
    assign mem_write = mem_write_q;
    assign if_ack = if_ack_q;
    assign d_ack = d_ack_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata = d_rdata_q;
    assign stall = if_go | d_go;
endmodule
